instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the LEGv8 pipeline. It produces the 32-bit instruction stream that the decode controller consumes; decode takes opcode bits [31:21] from `instr`. The unit owns the PC, issues reads to a synchronous instruction memory with one-cycle latency, and buffers returned words in a small FIFO. Decode drains that FIFO through a valid/ready handshake, and branch resolution redirects the PC and flushes stale instructions.

## Interface
- `N`, 64: PC / address width.
- `DEPTH`, 2: instruction buffer entries; minimum 2.
- `RESET_PC`, 0: PC loaded on reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  N  byte address of the request; always word-aligned.
- `imem_rvalid`  in  1  response valid; asserted exactly 1 cycle after `imem_req`.
- `imem_rdata`  in  32  response word.
- `redirect`  in  1  taken branch; flush and restart.
- `redirect_pc`  in  N  restart address.
- `instr_valid`  out  1  head of buffer valid.
- `instr`  out  32  head instruction.
- `instr_pc`  out  N  address of `instr`.
- `instr_ready`  in  1  decode accepts the head this cycle.

## Operation
- Reset values: `pc` = `RESET_PC`, buffer empty, no request in flight, `instr_valid` = 0, `imem_req` = 0, `instr`/`instr_pc` = 0, counters = 0.
- Pop: a pop occurs when `instr_valid && instr_ready`.
- Issue: assert `imem_req` when `count + inflight - pop < DEPTH`.
  - `count` is the buffer occupancy. `inflight` is 1 if a request was issued last cycle.
  - `imem_addr` = `pc`. On issue, `pc <= pc + 4`, wrapping modulo 2^N.
- Response: when `imem_rvalid` is high and not killed, push {`imem_rdata`, address of the request} into the buffer.
  - The issue rule guarantees the buffer never overflows.
  - A push into a full buffer is an assertion failure.
- Push and pop in the same cycle: both take effect and `count` is unchanged.
- Redirect at cycle t:
  - `pc <= redirect_pc` with bits [1:0] forced to 0.
  - The buffer is flushed, and a pop in the same cycle is ignored.
  - `imem_rvalid` at cycle t is dropped.
  - A request issued at cycle t is marked killed, so its response at t+1 is dropped.
  - `imem_req` is not gated combinationally by `redirect`.
- Back-to-back redirects: the last one wins, and each one kills the preceding in-flight request.
- `reset` overrides `redirect` and any in-flight response.
- No combinational path from `instr_ready` or `redirect` to `imem_req` or `imem_addr`.

## Timing
- Reset deasserted at cycle 0:
  - `imem_req` at cycle 0 with `imem_addr` = `RESET_PC`.
  - `imem_rvalid` at cycle 1.
  - `instr_valid` at cycle 2.
- Redirect at t: request to `redirect_pc` at t+1, response at t+2, `instr_valid` with `instr_pc` = `redirect_pc` at t+3.
- Sustained throughput with `instr_ready` held at 1: one instruction per cycle.
- Stall: while `instr_ready` = 0, the buffer fills to `DEPTH` and `imem_req` stays low until a pop.
- `instr`, `instr_pc` and `instr_valid` come directly from registers.

## Configuration
- `INSTR_FETCH_PERF_EN` defined: adds output ports `perf_fetched` [31:0] and `perf_flushes` [31:0].
  - `perf_fetched` counts pops.
  - `perf_flushes` counts redirect cycles.
  - Both wrap at 2^32 and reset to 0.
- `INSTR_FETCH_PERF_EN` not defined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package `fetch_pkg`:
  - `INSTR_W` = 32, `PC_INC` = 4.
  - `fetch_entry_t` packed struct {`pc`, `instr`}, parameterised by `N` via the default 64.
- Sub-module `instr_fifo`:
  - `DEPTH`-entry synchronous FIFO of `fetch_entry_t` with push, pop and flush.
  - Flush has priority over push in the same cycle.
  - Exposes `count`, `empty` and `full`.
- Top level holds `pc`, the in-flight/kill flags, the issue logic and the optional counters.

## Test plan
- Reset release, `RESET_PC` = 0, `instr_ready` = 1, memory returns addr>>2 → `instr_pc` = 0, 4, 8… on consecutive cycles from cycle 2, one per cycle.
- `instr_ready` = 0 for 6 cycles → at most 2 requests issued, `imem_req` then low; on ready, `instr` order 0, 4 with no loss or duplicate.
- Redirect to 0x100 while buffer full and a request in flight → `instr_valid` low at t+1 and t+2, `instr_pc` = 0x100 at t+3, no stale word ever presented.
- Redirects at t and t+1 (0x40, then 0x80) → next valid `instr_pc` = 0x80; 0x40 never appears.
- Redirect to 0x103 → fetch from 0x100; `pc` wraps from 0xFFFF_FFFF_FFFF_FFFC to 0.
- Reset asserted mid-stream with pending response → next cycle all outputs at reset values, and the response is dropped.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the buffer entry type for the LEGv8
// instruction fetch unit.
//   INSTR_W       instruction word width (32)
//   PC_INC        PC increment per fetched word (4)
//   PC_W          PC width carried in a buffer entry (64)
//   fetch_entry_t {pc, instr} as held in the instruction buffer
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;
  localparam int PC_W    = 64;

  // A top level with N < PC_W zero-extends into pc and slices it back out.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
// The buffer is a shift queue, so the head entry is always entry 0. This
// keeps the head outputs coming straight from flops.
// Ports:
//   clk, srst      clock, synchronous active-high reset
//   push_i         write push_data_i at the tail
//   push_data_i    entry to write
//   pop_i          drop the head (ignored when empty)
//   flush_i        empty the buffer; wins over a push in the same cycle
//   head_o         head entry (registered)
//   head_valid_o   head entry holds data (registered)
//   count_o        occupancy
//   empty_o        count_o == 0
//   full_o         count_o == DEPTH
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic          head_valid_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  fetch_entry_t  entry_q   [DEPTH];
  fetch_entry_t  shift_src [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_idx;
  logic          valid_q;
  logic          pop_ok;

  assign pop_ok = pop_i & valid_q;

  // When a pop and a push coincide, the tail slot moves down by one
  // before the new entry lands.
  always_comb begin
    wr_idx  = count_q - CW'(pop_ok);
    count_d = count_q + CW'(push_i) - CW'(pop_ok);
    if (flush_i) begin
      count_d = '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi < DEPTH - 1) begin : g_mid
        assign shift_src[gi] = entry_q[gi+1];
      end else begin : g_tail
        assign shift_src[gi] = entry_q[gi];
      end

      always_ff @(posedge clk) begin
        if (srst) begin
          entry_q[gi] <= '0;
        end else if (!flush_i) begin
          if (push_i && (wr_idx == CW'(gi))) begin
            entry_q[gi] <= push_data_i;
          end else if (pop_ok) begin
            entry_q[gi] <= shift_src[gi];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign head_o       = entry_q[0];
  assign head_valid_o = valid_q;
  assign count_o      = count_q;
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: LEGv8 instruction fetch unit. Owns the PC, issues reads to a
// one-cycle-latency instruction memory, and buffers the returned words for
// decode. Branch redirects flush the buffer and kill the in-flight request.
// Optional feature macro: INSTR_FETCH_PERF_EN adds perf_fetched and
// perf_flushes counters (32-bit, wrapping).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   imem_req/imem_addr   memory read request and word-aligned byte address
//   imem_rvalid/rdata    memory response, one cycle after the request
//   redirect/redirect_pc taken branch and its restart address
//   instr_valid/instr/instr_pc/instr_ready  handshake toward decode
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          N        = 64,
  parameter int          DEPTH    = 2,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [N-1:0]       redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [N-1:0]       instr_pc,
  input  logic               instr_ready
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushes
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [N-1:0]  pc_q, pc_d;
  logic [N-1:0]  req_addr_q;
  logic          inflight_q;
  logic          killed_q;
  logic          pop, fifo_pop, push, issue;
  logic [OW-1:0] occupancy;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full, head_valid;
  fetch_entry_t  push_entry, head_entry;

  assign pop      = head_valid & instr_ready;
  // A flush discards the head, so a same-cycle pop has nothing to take.
  assign fifo_pop = pop & ~redirect;
  // Responses are dropped when they belong to a killed request or arrive
  // while a redirect is flushing the buffer.
  assign push     = imem_rvalid & ~killed_q & ~redirect;

  // Crediting the pop lets a buffer of two sustain one fetch per cycle.
  // Redirect is deliberately absent: a request issued alongside a redirect
  // is simply marked killed.
  always_comb begin
    occupancy = {1'b0, fifo_count} + OW'(inflight_q) - OW'(pop);
    issue     = ~reset & (occupancy < OW'(DEPTH));
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc & ~N'(3);
    end else if (issue) begin
      pc_d = pc_q + N'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      inflight_q <= 1'b0;
      killed_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      killed_q   <= issue & redirect;
      if (issue) begin
        req_addr_q <= pc_q;
      end
    end
  end

  assign push_entry.pc    = PC_W'(req_addr_q);
  assign push_entry.instr = imem_rdata;

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .srst         (reset),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (fifo_pop),
    .flush_i      (redirect),
    .head_o       (head_entry),
    .head_valid_o (head_valid),
    .count_o      (fifo_count),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign instr_valid = head_valid;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc[N-1:0];

  // The issue rule keeps the buffer from ever overflowing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && fifo_full));
      assert (!(fifo_pop && fifo_empty));
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_flushes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (fifo_pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (redirect) begin
        perf_flushes_q <= perf_flushes_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch. A queue-based
// reference model predicts every cycle's outputs. A vector table covers
// reset release, sustained streaming and the stall case. Hand sequences cover
// redirects, alignment, PC wrap and mid-stream reset, followed by a random phase.
module tb_instr_fetch;

  localparam int          N        = 64;
  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready = 1'b0;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushes;
`endif

  instr_fetch #(
    .N        (N),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushes (perf_flushes)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: buffered words, the PC, and the in-flight request.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t        mq[$];
  logic [63:0] m_pc = RESET_PC;
  logic [63:0] m_fl_addr = '0;
  bit          m_fl = 1'b0;
  bit          m_kill = 1'b0;
  bit          chk_en = 1'b0;

  // Bench memory: answers the DUT's request one cycle later.
  bit          mem_pend = 1'b0;
  logic [63:0] mem_addr = '0;

  // Values sampled in the most recent step.
  logic        s_req, s_valid;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] memf(logic [63:0] a);
    logic [63:0] sh;
    sh = a >> 2;
    return sh[31:0];
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample, compare
  // with the model, advance the model, then wait for the rising edge.
  task automatic step(bit rst, bit rdy, bit rdr, logic [63:0] rpc);
    bit pop;
    bit e_req;
    int occ;
    @(negedge clk);
    reset       = rst;
    instr_ready = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    imem_rvalid = mem_pend;
    imem_rdata  = mem_pend ? memf(mem_addr) : 32'hDEAD_BEEF;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_pc    = instr_pc;
    s_instr = instr;

    pop   = (mq.size() > 0) && rdy;
    occ   = mq.size() + int'(m_fl) - int'(pop);
    e_req = !rst && (occ < DEPTH);
    if (chk_en) begin
      check("instr_valid", s_valid, 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("instr_pc", s_pc, mq[0].pc);
        check("instr", s_instr, 64'(mq[0].ins));
      end
      check("imem_req", s_req, 64'(e_req));
      if (e_req) check("imem_addr", s_addr, m_pc);
    end

    if (rst) begin
      mq.delete();
      m_pc   = RESET_PC;
      m_fl   = 1'b0;
      m_kill = 1'b0;
    end else begin
      if (rdr) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_fl && !m_kill) mq.push_back('{m_fl_addr, memf(m_fl_addr)});
      end
      m_kill    = rdr && e_req;
      m_fl      = e_req;
      m_fl_addr = m_pc;
      if (rdr) m_pc = rpc & ~64'h3;
      else if (e_req) m_pc = m_pc + 64'd4;
    end

    mem_pend = s_req;
    mem_addr = s_addr;
    @(posedge clk);
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          e_req;
    logic [63:0] e_addr;
    bit          e_valid;
    logic [63:0] e_pc;
    bit          e_zero;
  } vec_t;

  function automatic vec_t mk(bit rst, bit rdy, bit e_req, logic [63:0] e_addr,
                              bit e_valid, logic [63:0] e_pc, bit e_zero);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_zero = e_zero;
    return v;
  endfunction

  vec_t vt[17];

  initial begin
    // Reset release with ready held high: one instruction per cycle.
    vt[0]  = mk(1, 1, 0, 0,    0, 0,    1);
    vt[1]  = mk(0, 1, 1, 0,    0, 0,    0);
    vt[2]  = mk(0, 1, 1, 4,    0, 0,    0);
    vt[3]  = mk(0, 1, 1, 8,    1, 0,    0);
    vt[4]  = mk(0, 1, 1, 12,   1, 4,    0);
    vt[5]  = mk(0, 1, 1, 16,   1, 8,    0);
    // Reset mid-stream, then ready low for six cycles, then ready again.
    vt[6]  = mk(1, 0, 0, 0,    1, 12,   0);
    vt[7]  = mk(1, 0, 0, 0,    0, 0,    1);
    vt[8]  = mk(0, 0, 1, 0,    0, 0,    0);
    vt[9]  = mk(0, 0, 1, 4,    0, 0,    0);
    vt[10] = mk(0, 0, 0, 0,    1, 0,    0);
    vt[11] = mk(0, 0, 0, 0,    1, 0,    0);
    vt[12] = mk(0, 0, 0, 0,    1, 0,    0);
    vt[13] = mk(0, 0, 0, 0,    1, 0,    0);
    vt[14] = mk(0, 1, 1, 8,    1, 0,    0);
    vt[15] = mk(0, 1, 1, 12,   1, 4,    0);
    vt[16] = mk(0, 1, 1, 16,   1, 8,    0);

    step(1, 0, 0, 0);
    chk_en = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vt[i].rst, vt[i].rdy, 1'b0, 64'h0);
      check("vec_req", s_req, 64'(vt[i].e_req));
      if (vt[i].e_req) check("vec_addr", s_addr, vt[i].e_addr);
      check("vec_valid", s_valid, 64'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        check("vec_pc", s_pc, vt[i].e_pc);
        check("vec_instr", s_instr, 64'(memf(vt[i].e_pc)));
      end
      if (vt[i].e_zero) begin
        check("vec_rst_pc", s_pc, 64'h0);
        check("vec_rst_instr", s_instr, 64'h0);
      end
    end

    // Redirect to 0x100 while a word is buffered and a response is arriving.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 64'h100);
    step(0, 1, 0, 0);
    check("c_t1_req", s_req, 1);
    check("c_t1_addr", s_addr, 64'h100);
    check("c_t1_valid", s_valid, 0);
    step(0, 1, 0, 0);
    check("c_t2_valid", s_valid, 0);
    step(0, 1, 0, 0);
    check("c_t3_valid", s_valid, 1);
    check("c_t3_pc", s_pc, 64'h100);
    check("c_t3_instr", s_instr, 64'h40);

    // Back-to-back redirects: the second target wins.
    step(0, 1, 1, 64'h40);
    step(0, 1, 1, 64'h80);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, 0);
      check("bb_gap_valid", s_valid, 0);
    end
    step(0, 1, 0, 0);
    check("bb_first_valid", s_valid, 1);
    check("bb_first_pc", s_pc, 64'h80);
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, 0);
      check("bb_no_0x40", 64'(s_valid && (s_pc == 64'h40)), 0);
    end

    // Misaligned redirect target and PC wrap at the top of the address space.
    step(0, 1, 1, 64'h103);
    step(0, 1, 0, 0);
    check("al_addr", s_addr, 64'h100);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("al_pc", s_pc, 64'h100);
    step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    step(0, 1, 0, 0);
    check("wr_addr0", s_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    step(0, 1, 0, 0);
    check("wr_addr1", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 1, 0, 0);
    check("wr_addr2", s_addr, 64'h0);
    check("wr_pc0", s_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    step(0, 1, 0, 0);
    check("wr_pc1", s_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 1, 0, 0);
    check("wr_pc2", s_pc, 64'h0);
    step(0, 1, 0, 0);
    check("wr_pc3", s_pc, 64'h4);

    // Reset for one cycle while a response is on the bus.
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("rs_req_during", s_req, 0);
    step(0, 1, 0, 0);
    check("rs_valid", s_valid, 0);
    check("rs_instr", s_instr, 64'h0);
    check("rs_pc", s_pc, 64'h0);
    check("rs_req", s_req, 1);
    check("rs_addr", s_addr, RESET_PC);
    step(0, 1, 0, 0);
    check("rs_valid2", s_valid, 0);
    step(0, 1, 0, 0);
    check("rs_first_valid", s_valid, 1);
    check("rs_first_pc", s_pc, 64'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      bit rst, rdr, rdy;
      logic [63:0] rpc;
      r   = $urandom_range(0, 99);
      rst = (r < 2);
      rdr = (r >= 2) && (r < 12);
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) rpc = {32'hFFFF_FFFF, 32'($urandom)};
      else rpc = {32'h0, 32'($urandom)};
      step(rst, rdy, rdr, rpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
